// File: rtl/mem_cmd_queue.sv
// mem_cmd_queue: small request FIFO in front of memory_controller.
// Issues one queued command at a time over cmd/addr/wdata/ready, waits for
// valid (or a timeout), then retires the request with a one-cycle response.
module mem_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic [1:0]             cmd,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  input  logic                   valid,
  output logic                   rsp_valid,
  output logic                   rsp_write,
  output logic                   rsp_timeout,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int EW = 1 + ADDR_W + DATA_W;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [1:0]    CMD_NONE = 2'b00;
  localparam logic [1:0]    CMD_WR   = 2'b10;
  localparam logic [1:0]    CMD_RD   = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state;
  logic [EW-1:0]       fifo_mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [TW-1:0]       tcnt;
  logic                push;
  logic                pop;
  logic                head_write;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_wdata;

  // Acceptance depends only on registered occupancy, so a full queue
  // refuses a push even in the cycle the head is being retired.
  assign req_ready = (count < FULL_CNT);

  assign {head_write, head_addr, head_wdata} = fifo_mem[rd_ptr];

  // Push/pop qualifiers: pop happens on the edge the outstanding command retires.
  always_comb begin
    push = req_valid && req_ready;
    pop  = (state == S_WAIT) && (valid || (tcnt == T_LAST));
  end

  // Request storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_write, req_addr, req_wdata};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: load head, strobe ready once, wait for valid/timeout, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd         <= CMD_NONE;
      addr        <= '0;
      wdata       <= '0;
      ready       <= 1'b0;
      tcnt        <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd <= CMD_NONE;
          if (count != '0) begin
            cmd   <= head_write ? CMD_WR : CMD_RD;
            addr  <= head_addr;
            wdata <= head_wdata;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ready <= 1'b1;
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          ready <= 1'b0;
          if (valid) begin
            if (cmd == CMD_RD) rsp_rdata <= rdata;
            rsp_timeout <= 1'b0;
            rsp_write   <= (cmd == CMD_WR);
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else if (tcnt == T_LAST) begin
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            rsp_write   <= (cmd == CMD_WR);
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          cmd       <= CMD_NONE;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_queue.sv
// tb_mem_cmd_queue: randomized and directed checks of mem_cmd_queue against a
// queue-based reference with a simple memory_controller stand-in.
module tb_mem_cmd_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 25;
  localparam int DW    = 16;
  localparam int TO    = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic [1:0]    cmd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;
  logic          ready;
  logic          valid = 1'b0;
  logic          rsp_valid;
  logic          rsp_write;
  logic          rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [2:0]    count;

  mem_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .cmd(cmd), .addr(addr), .wdata(wdata), .rdata(rdata),
    .ready(ready), .valid(valid),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_timeout(rsp_timeout),
    .rsp_rdata(rsp_rdata), .count(count)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  // Reference state
  req_t          q[$];
  req_t          cur;
  logic [DW-1:0] mem_m [logic [AW-1:0]];
  int            cyc, issue_at, rsp_cyc, free_cyc, lat, force_lat, spur_mode;
  bit            outstanding, stall;
  logic [1:0]    exp_cmd;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_rdata;
  logic          exp_rw, exp_to;

  // Observations from the DUT
  int            obs_ready_cyc, obs_rsp_cyc, n_ready, n_rsp;
  logic [1:0]    obs_cmd;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata, obs_rd;
  logic          obs_rw, obs_to;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic check_cycle();
    chk("count", count, 64'(q.size()));
    chk("req_ready", req_ready, q.size() < DEPTH);
    chk("ready", ready, outstanding && (cyc == issue_at));
    chk("cmd", cmd, exp_cmd);
    chk("addr", addr, exp_addr);
    chk("wdata", wdata, exp_wdata);
    chk("rsp_valid", rsp_valid, cyc == rsp_cyc);
    chk("rsp_write", rsp_write, exp_rw);
    chk("rsp_timeout", rsp_timeout, exp_to);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    if (ready === 1'b1) begin
      obs_ready_cyc = cyc; obs_cmd = cmd; obs_addr = addr; obs_wdata = wdata;
      n_ready++;
    end
    if (rsp_valid === 1'b1) begin
      obs_rsp_cyc = cyc; obs_rw = rsp_write; obs_to = rsp_timeout; obs_rd = rsp_rdata;
      n_rsp++;
    end
  endtask

  // One clock: drive the controller stand-in, predict the edge, then check.
  task automatic step();
    int e;
    bit win, acc, tmo, do_push;
    req_t r;
    e = cyc + 1;
    win = outstanding && (e >= issue_at + 1) && (e <= issue_at + TO);
    if (win && !stall && (e >= issue_at + lat)) begin
      valid = 1'b1;
      if (!cur.wr && mem_m.exists(cur.a)) rdata = mem_m[cur.a];
      else rdata = DW'($urandom);
    end else begin
      valid = !win && (spur_mode == 2 || (spur_mode == 1 && $urandom_range(0, 3) == 0));
      rdata = DW'($urandom);
    end
    acc = win && valid;
    tmo = win && !valid && (e == issue_at + TO);
    do_push = req_valid && (q.size() < DEPTH);
    if (acc || tmo) begin
      if (acc && cur.wr) mem_m[cur.a] = cur.d;
      exp_rw = cur.wr;
      exp_to = tmo;
      if (tmo) exp_rdata = '0;
      else if (!cur.wr) exp_rdata = rdata;
      void'(q.pop_front());
      outstanding = 0;
      rsp_cyc = e;
      free_cyc = e + 1;
      issue_at = -1;
    end
    if (do_push) begin
      r.wr = req_write; r.a = req_addr; r.d = req_wdata;
      q.push_back(r);
    end
    @(posedge clk);
    cyc = e;
    if (cyc == rsp_cyc + 1) exp_cmd = 2'b00;
    if (issue_at >= 0 && cyc == issue_at - 1) begin
      exp_cmd = cur.wr ? 2'b10 : 2'b01;
      exp_addr = cur.a;
      exp_wdata = cur.d;
    end
    if (issue_at >= 0 && cyc == issue_at) begin
      outstanding = 1;
      if (force_lat > 0) lat = force_lat;
      else if ($urandom_range(0, 7) == 0) lat = TO + 1;
      else lat = int'($urandom_range(1, 6));
    end
    if (!outstanding && issue_at < 0 && q.size() > 0 && cyc >= free_cyc) begin
      issue_at = cyc + 2;
      cur = q[0];
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int n0, i;
    n0 = n_rsp; i = 0;
    while (n_rsp == n0 && i < budget) begin step(); i++; end
    chk("rsp_arrived", n_rsp != n0, 1);
  endtask

  task automatic wait_ready(input int budget);
    int n0, i;
    n0 = n_ready; i = 0;
    while (n_ready == n0 && i < budget) begin step(); i++; end
    chk("ready_arrived", n_ready != n0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0; req_valid = 1'b0; valid = 1'b0;
    #1;
    chk("rst_cmd", cmd, 2'b00);
    chk("rst_ready", ready, 0);
    chk("rst_count", count, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    q.delete();
    outstanding = 0; issue_at = -1; rsp_cyc = -10; free_cyc = 0;
    exp_cmd = '0; exp_addr = '0; exp_wdata = '0; exp_rw = 0; exp_to = 0; exp_rdata = '0;
    stall = 0; spur_mode = 0; force_lat = 0; lat = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int t_push, t_rsp, n_before;
    cyc = 0; n_ready = 0; n_rsp = 0;
    do_reset();
    repeat (3) step();

    // Single write, controller answers 5 cycles after ready
    force_lat = 5;
    push_req(1'b1, 25'h0FFFF, 16'hAAAA);
    t_push = cyc;
    wait_rsp(40);
    chk("wr_issue_lat", 64'(obs_ready_cyc - t_push), 2);
    chk("wr_cmd", obs_cmd, 2'b10);
    chk("wr_addr", obs_addr, 25'h0FFFF);
    chk("wr_wdata", obs_wdata, 16'hAAAA);
    chk("wr_rsp_lat", 64'(obs_rsp_cyc - obs_ready_cyc), 5);
    chk("wr_rsp_write", obs_rw, 1);
    chk("wr_rsp_timeout", obs_to, 0);

    // Read back the same address
    push_req(1'b0, 25'h0FFFF, 16'h1234);
    wait_rsp(40);
    chk("rd_cmd", obs_cmd, 2'b01);
    chk("rd_rdata", obs_rd, 16'hAAAA);
    chk("rd_rsp_write", obs_rw, 0);
    repeat (2) step();

    // Fill with a stalled controller, refuse a fifth, then drain and wrap
    stall = 1;
    for (int i = 0; i < 4; i++) push_req(1'(i), AW'(32'h100 + i), DW'(32'hC000 + i));
    chk("full_count", count, 4);
    chk("full_req_ready", req_ready, 0);
    req_write = 1'b1; req_addr = 25'h1FF; req_wdata = 16'hDEAD; req_valid = 1'b1;
    repeat (3) step();
    req_valid = 1'b0;
    chk("full_refused_count", count, 4);
    stall = 0; force_lat = 2;
    repeat (4) wait_rsp(60);
    for (int i = 0; i < 4; i++) push_req(1'(~i), AW'(32'h200 + i), DW'(32'hD000 + i));
    repeat (4) wait_rsp(60);

    // Timeout, then the queued command issues
    stall = 1;
    push_req(1'b0, 25'h3333, 16'h0000);
    push_req(1'b1, 25'h4444, 16'hBEEF);
    wait_rsp(80);
    chk("to_latency", 64'(obs_rsp_cyc - obs_ready_cyc), 20);
    chk("to_flag", obs_to, 1);
    chk("to_rdata", obs_rd, 16'h0000);
    t_rsp = obs_rsp_cyc;
    stall = 0; force_lat = 3;
    wait_ready(20);
    chk("next_issue_gap", 64'(obs_ready_cyc - t_rsp), 3);
    chk("next_issue_addr", obs_addr, 25'h4444);
    wait_rsp(40);

    // Spurious valid while idle and during the load/issue cycles
    spur_mode = 2;
    repeat (6) step();
    push_req(1'b1, 25'h55, 16'h5555);
    wait_rsp(40);
    chk("spur_rsp_lat", 64'(obs_rsp_cyc - obs_ready_cyc), 3);
    spur_mode = 0; force_lat = 0;

    // Randomized traffic with occasional timeouts and spurious valids
    spur_mode = 1;
    for (int i = 0; i < 800; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 7));
      req_wdata = DW'($urandom);
      step();
    end
    req_valid = 1'b0;
    spur_mode = 0;
    for (int i = 0; i < 300 && (q.size() > 0 || outstanding || issue_at >= 0); i++) step();
    chk("drained", 64'(q.size()), 0);

    // Reset while a read is waiting: dropped without a response
    stall = 1;
    push_req(1'b0, 25'h0ABCD, 16'h0000);
    repeat (4) step();
    chk("mid_wait_cmd", cmd, 2'b01);
    n_before = n_rsp;
    do_reset();
    repeat (30) step();
    chk("no_rsp_after_reset", n_rsp == n_before, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
